// File: rtl/key_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer_if
// Description : Key line bundle between board pins and the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_debouncer_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] key_raw;
    logic [WIDTH-1:0] key_level;
    logic [WIDTH-1:0] key_pressed;
    logic [WIDTH-1:0] key_released;
    logic             key_any;

    modport master (
        output key_raw,
        input  key_level,
        input  key_pressed,
        input  key_released,
        input  key_any
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_pressed,
        output key_released,
        output key_any
    );
endinterface
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : Per-line synchroniser and debouncer with press/release strobes.
//               Optional auto-repeat on held keys: KEY_DEBOUNCER_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  wire logic      clock,
    input  wire logic      reset,
    key_debouncer_if.slave bus
);

    localparam int               C_CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int C_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int C_REP_W   = (C_REP_MAX > 2) ? $clog2(C_REP_MAX) : 1;
    localparam logic [C_REP_W-1:0] C_REP_DELAY_LAST  = C_REP_W'(REPEAT_DELAY - 1);
    localparam logic [C_REP_W-1:0] C_REP_PERIOD_LAST = C_REP_W'(REPEAT_PERIOD - 1);
`endif

    // Elaboration-time guard on the configuration
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_debouncer: illegal DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
    end

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_DB_DOWN = 2'd1,
        ST_DOWN    = 2'd2,
        ST_DB_UP   = 2'd3
    } state_t;

    logic [WIDTH-1:0] w_raw_hi;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_pressed;
    logic [WIDTH-1:0] w_released;

    assign w_raw_hi = bus.key_raw ^ {WIDTH{ACTIVE_LOW}};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw_hi;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_line
        state_t             r_state;
        logic [C_CNT_W-1:0] r_cnt;
        logic               r_level;
        logic               r_pressed;
        logic               r_released;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
        logic [C_REP_W-1:0] r_rep_cnt;
        logic               r_rep_armed;
`endif

        always_ff @(posedge clock) begin
            if (reset) begin
                r_state    <= ST_UP;
                r_cnt      <= '0;
                r_level    <= 1'b0;
                r_pressed  <= 1'b0;
                r_released <= 1'b0;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b0;
`endif
            end else begin
                r_pressed  <= 1'b0;
                r_released <= 1'b0;
                case (r_state)
                    ST_UP: begin
                        if (r_sync2[i]) begin
                            r_state <= ST_DB_DOWN;
                            r_cnt   <= C_CNT_W'(1);
                        end
                    end
                    ST_DB_DOWN: begin
                        if (!r_sync2[i]) begin
                            r_state <= ST_UP;
                            r_cnt   <= '0;
                        end else if (r_cnt == C_CNT_LAST) begin
                            r_state   <= ST_DOWN;
                            r_cnt     <= '0;
                            r_level   <= 1'b1;
                            r_pressed <= 1'b1;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
                            r_rep_cnt   <= '0;
                            r_rep_armed <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_DOWN: begin
                        if (!r_sync2[i]) begin
                            r_state <= ST_DB_UP;
                            r_cnt   <= C_CNT_W'(1);
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
                        // First strobe after the hold delay, then one per period
                        end else if (!r_rep_armed) begin
                            if (r_rep_cnt == C_REP_DELAY_LAST) begin
                                r_pressed   <= 1'b1;
                                r_rep_cnt   <= '0;
                                r_rep_armed <= 1'b1;
                            end else begin
                                r_rep_cnt <= r_rep_cnt + 1'b1;
                            end
                        end else if (r_rep_cnt == C_REP_PERIOD_LAST) begin
                            r_pressed <= 1'b1;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
`endif
                        end
                    end
                    ST_DB_UP: begin
                        if (r_sync2[i]) begin
                            // Bounce back to held: no strobe, repeat delay restarts
                            r_state <= ST_DOWN;
                            r_cnt   <= '0;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
                            r_rep_cnt   <= '0;
                            r_rep_armed <= 1'b0;
`endif
                        end else if (r_cnt == C_CNT_LAST) begin
                            r_state    <= ST_UP;
                            r_cnt      <= '0;
                            r_level    <= 1'b0;
                            r_released <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_UP;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_level[i]    = r_level;
        assign w_pressed[i]  = r_pressed;
        assign w_released[i] = r_released;
    end

    assign bus.key_level    = w_level;
    assign bus.key_pressed  = w_pressed;
    assign bus.key_released = w_released;
    assign bus.key_any      = |w_level;

endmodule
`default_nettype wire

// File: doc/key_debouncer.md
# key_debouncer

Input-side conditioning block for the board's push buttons and slide switches. It synchronises raw, bouncing, optionally active-low button lines into the `clock` domain and debounces each line independently. It produces clean active-high levels plus one-cycle press and release strobes. It sits between the board pins and any logic that counts, steps or selects on user input.

## Interface

Parameters:
- `WIDTH`, 4: number of independent input lines.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before a change is accepted (10 ms at 50 MHz); legal range is 2 and above.
- `ACTIVE_LOW`, 1: when 1, a raw 0 means pressed, as on the board's keys. When 0, a raw 1 means pressed.
- `REPEAT_DELAY`, 25000000: cycles a line must be held before auto-repeat starts. Used only with the macro in Configuration.
- `REPEAT_PERIOD`, 5000000: cycles between auto-repeat strobes. Used only with the macro in Configuration.

Ports:
- `clock`, input, 1: single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `key_raw`, input, `WIDTH`: asynchronous raw pin levels.
- `key_level`, output, `WIDTH`: debounced state; 1 means pressed, after polarity correction.
- `key_pressed`, output, `WIDTH`: one-cycle strobe when a line becomes pressed, and on each auto-repeat.
- `key_released`, output, `WIDTH`: one-cycle strobe when a line becomes released.
- `key_any`, output, 1: OR of `key_level`.

## Operation

- Polarity: each raw bit is XORed with `ACTIVE_LOW` before synchronisation. All internal logic is active-high.
- Synchronisation: two-flop synchroniser per bit, giving the synchronised value `s`.
- Per-line state machine; all lines are identical and independent:
  - UP: `key_level`=0, counter held at 0. If `s`=1, go to DB_DOWN with counter=1.
  - DB_DOWN: if `s`=0, return to UP and clear the counter. Otherwise, when counter = `DEBOUNCE_CYCLES`−1, go to DOWN, set `key_level`=1 and pulse `key_pressed`. Otherwise increment the counter.
  - DOWN: `key_level`=1. If `s`=0, go to DB_UP with counter=1.
  - DB_UP: the mirror of DB_DOWN. A stable 0 sustained long enough sets `key_level`=0, pulses `key_released` and returns to UP. A 1 during debounce returns to DOWN with no strobe.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. It never wraps, because it is cleared on every bounce.
- Bounces shorter than `DEBOUNCE_CYCLES` produce no output activity at all.
- `key_pressed` and `key_released` of the same bit are never high together.
- Different bits may strobe in the same cycle.

## Timing

- Reset (synchronous, active-high) sets the following, and takes precedence over all else on the same edge:
  - All states to UP.
  - All counters to 0.
  - Synchroniser flops to 0, meaning released after polarity correction.
  - `key_level`=0, `key_pressed`=0, `key_released`=0, `key_any`=0.
- Latency: suppose a clean raw transition is stable before rising edge N.
  - `key_level` and its strobe update on edge N+1+`DEBOUNCE_CYCLES`.
  - The strobe is high for exactly one cycle, from that edge to the next.
- `key_any` is combinational from registered `key_level`. It has no added latency.
- Reset mid-debounce or mid-hold:
  - Outputs go to 0 with no release strobe.
  - A key still held after reset is re-debounced and produces a fresh `key_pressed`.
- Lines held pressed through reset release must satisfy the full debounce time before being reported.

## Configuration

- Macro: `KEY_DEBOUNCER_AUTOREPEAT_EN`.
- Defined:
  - Each line has a repeat counter, cleared on entry to DOWN.
  - After `REPEAT_DELAY` cycles in DOWN, `key_pressed` pulses one cycle, then again every `REPEAT_PERIOD` cycles while the line stays in DOWN.
  - Leaving DOWN for DB_UP stops repeats immediately. A bounce back to DOWN restarts the delay from 0.
- Undefined:
  - No repeat counters are built.
  - `key_pressed` fires only once per accepted press.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan

All scenarios use `WIDTH`=4, `DEBOUNCE_CYCLES`=4 and `ACTIVE_LOW`=1.
- Clean press: `key_raw` goes from 4'hF to 4'hE before edge 10.
  - `key_level` becomes 4'h1 and `key_pressed` is 4'h1 for one cycle, at edge 15.
  - `key_any`=1.
- Bounce rejection: `key_raw[0]` toggles every 2 cycles for 20 cycles, then settles at 1 (released).
  - `key_level`, `key_pressed` and `key_released` stay 0 throughout.
- Release: from held state with `key_level`=4'h1, `key_raw` goes to 4'hF before edge N.
  - `key_released`=4'h1 for one cycle at edge N+5.
  - `key_level`=0.
- Simultaneous lines: bits 1 and 3 press on the same cycle.
  - `key_pressed`=4'hA for one cycle; `key_level`=4'hA.
- Reset mid-hold: key 2 is held and `key_level`=4'h4, then `reset` is asserted for 1 cycle while key 2 stays held.
  - Outputs are 0 the cycle after reset, with no release strobe.
  - `key_pressed`=4'h4 again 6 edges after reset is released.
- Auto-repeat, with the macro defined, `REPEAT_DELAY`=10 and `REPEAT_PERIOD`=3, key 0 held for 30 cycles:
  - An initial strobe.
  - Then strobes 10, 13, 16, … cycles after entry to DOWN.
  - None after release.
